// File: rtl/sub_vec_seq.sv
// Element-serial signed vector subtractor: out_vec = a_vec - b_vec, one element per clock,
// ready/valid on both sides, optional saturation with a sticky status flag.
module sub_vec_seq #(
   parameter int DIM       = 4,
   parameter int WIDTH     = 16,
   parameter int SATURATE  = 1,
   parameter     precision = "Q8.8"
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DIM*WIDTH-1:0] a_vec,
   input  logic [DIM*WIDTH-1:0] b_vec,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DIM*WIDTH-1:0] out_vec,
   output logic                 sat_flag,
   output logic                 busy
);
   localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
   localparam logic [IDX_W-1:0] LAST    = IDX_W'(DIM - 1);
   localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state, state_next;
   logic [IDX_W-1:0]     idx;
   logic [DIM*WIDTH-1:0] a_reg, b_reg;
   logic [WIDTH-1:0]     a_el, b_el, res;
   logic [WIDTH:0]       diff;
   logic                 ovf;
   logic                 accept;

   // precision only documents the Q format; the arithmetic is format-agnostic.
   if ($bits(precision) == 0) begin : g_no_precision
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      busy       = 1'b1;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            accept   = in_valid;
            if (in_valid) state_next = BUSY;
         end
         BUSY: begin
            if (idx == LAST) state_next = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Element mux by index over constant slices keeps every select in range for any DIM.
   always_comb begin
      a_el = '0;
      b_el = '0;
      for (int unsigned i = 0; i < DIM; i++) begin
         if (idx == IDX_W'(i)) begin
            a_el = a_reg[i*WIDTH +: WIDTH];
            b_el = b_reg[i*WIDTH +: WIDTH];
         end
      end
      diff = {a_el[WIDTH-1], a_el} - {b_el[WIDTH-1], b_el};
      ovf  = diff[WIDTH] ^ diff[WIDTH-1];
      if ((SATURATE != 0) && ovf) res = diff[WIDTH] ? MIN_VAL : MAX_VAL;
      else                        res = diff[WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg    <= '0;
         b_reg    <= '0;
         out_vec  <= '0;
         sat_flag <= 1'b0;
         idx      <= '0;
      end else if (accept) begin
         a_reg    <= a_vec;
         b_reg    <= b_vec;
         out_vec  <= '0;
         sat_flag <= 1'b0;
         idx      <= '0;
      end else if (state == BUSY) begin
         for (int unsigned i = 0; i < DIM; i++) begin
            if (idx == IDX_W'(i)) out_vec[i*WIDTH +: WIDTH] <= res;
         end
         if ((SATURATE != 0) && ovf) sat_flag <= 1'b1;
         idx <= (idx == LAST) ? '0 : idx + 1'b1;
      end
   end

endmodule
